mcu_spi_target: RTL and testbench

- SPI mode-0 target (CPOL=0, CPHA=0) on the link to the companion MCU.
- Oversamples the SPI lines in the system clock domain and assembles MOSI bytes, MSB first.
- Emits one-cycle byte strobes with a start-of-frame flag. These feed the OSD buffer writer's data_in_strobe / data_in_start / data_in directly.
- Shifts a reply byte out on MISO concurrently with each received byte.

---
 rtl/mcu_link_pkg.sv | 13 +
 rtl/sync_edge.sv | 46 ++++
 rtl/mcu_spi_target.sv | 123 ++++++++++++
 tb/tb_mcu_spi_target.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/mcu_link_pkg.sv
// Shared definitions for the companion-MCU link.
//
// Holds the command byte values that the downstream OSD logic decodes, and
// the default reply byte that the SPI target returns during the first byte
// of every frame. The MCU uses that reply to confirm it is talking to us.
package mcu_link_pkg;

  localparam logic [7:0] CMD_OSD_ENABLE   = 8'd1;
  localparam logic [7:0] CMD_OSD_WRITE    = 8'd2;

  localparam logic [7:0] FRAME_ID_DEFAULT = 8'h5C;

endpackage

// File: rtl/sync_edge.sv
// Multi-flop synchronizer with registered edge detection.
//
// Brings an asynchronous input into the clk domain. It then adds one extra
// register that serves two purposes: it is the level seen by the rest of
// the design, and it is the reference for edge detection. rise/fall are
// registered one-cycle pulses. They are time-aligned with `level`, so in
// a rise cycle `level` is already 1.
//
// Ports:
//   clk       system clock
//   reset     synchronous, active-high; chain and level load RESET_VAL
//   async_in  raw asynchronous input
//   level     synchronized level (the delayed register)
//   rise      one-cycle pulse on a synchronized 0->1 transition
//   fall      one-cycle pulse on a synchronized 1->0 transition
module sync_edge #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RESET_VAL   = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] chain;

  always_ff @(posedge clk) begin
    if (reset) begin
      chain <= {SYNC_STAGES{RESET_VAL}};
      level <= RESET_VAL;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], async_in};
      level <= chain[SYNC_STAGES-1];
      // Compare the newest synchronized sample against the delayed one.
      // The result lands in the same cycle that `level` takes the new value.
      rise  <= chain[SYNC_STAGES-1] & ~level;
      fall  <= ~chain[SYNC_STAGES-1] & level;
    end
  end

endmodule

// File: rtl/mcu_spi_target.sv
// SPI mode-0 target (CPOL=0, CPHA=0) for the companion-MCU link.
//
// All SPI lines are oversampled in the clk domain. MOSI bytes are assembled
// MSB first. Each complete byte is reported with a one-cycle strobe, and a
// start flag marks the first byte after chip select falls. A reply byte is
// shifted out on MISO at the same time as each byte is received. The first
// byte of every frame replies with FRAME_ID. Each later byte replies with
// whatever reply_in held during the previous strobe.
//
// Ports:
//   clk              system clock, at least 4x spi_sck
//   reset            synchronous, active-high
//   spi_csn          chip select from MCU, active low, asynchronous
//   spi_sck          SPI clock from MCU, asynchronous
//   spi_mosi         data from MCU, asynchronous
//   spi_miso         data to MCU (external tri-state enabled by !spi_csn)
//   reply_in         reply byte for the next slot, sampled during the strobe
//   data_out_strobe  one-cycle pulse per complete received byte
//   data_out_start   high with the strobe on the first byte of a frame
//   data_out         received byte, held until the next strobe
module mcu_spi_target
  import mcu_link_pkg::*;
#(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] FRAME_ID    = FRAME_ID_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       spi_csn,
  input  logic       spi_sck,
  input  logic       spi_mosi,
  output logic       spi_miso,
  input  logic [7:0] reply_in,
  output logic       data_out_strobe,
  output logic       data_out_start,
  output logic [7:0] data_out
);

  logic       cs_d, cs_fall, cs_rise_unused;
  logic       sck_d, sck_rise, sck_fall;
  logic       mosi_sync, mosi_rise_unused, mosi_fall_unused;
  logic [2:0] bit_cnt;
  logic       first;
  logic [7:0] rx_shift;
  logic [7:0] tx_shift;

  // Chip select idles high, so its synchronizer resets to 1. A reset
  // therefore never looks like the start of a frame.
  sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_csn (
    .clk      (clk),
    .reset    (reset),
    .async_in (spi_csn),
    .level    (cs_d),
    .rise     (cs_rise_unused),
    .fall     (cs_fall)
  );

  sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sck (
    .clk      (clk),
    .reset    (reset),
    .async_in (spi_sck),
    .level    (sck_d),
    .rise     (sck_rise),
    .fall     (sck_fall)
  );

  // MOSI is only sampled as a level on SCK rising edges.
  sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
    .clk      (clk),
    .reset    (reset),
    .async_in (spi_mosi),
    .level    (mosi_sync),
    .rise     (mosi_rise_unused),
    .fall     (mosi_fall_unused)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      bit_cnt         <= 3'd0;
      first           <= 1'b1;
      tx_shift        <= FRAME_ID;
      rx_shift        <= 8'h00;
      data_out        <= 8'h00;
      data_out_strobe <= 1'b0;
      data_out_start  <= 1'b0;
    end else begin
      data_out_strobe <= 1'b0;
      data_out_start  <= 1'b0;
      // A deselected link (including the cycle CS rises) takes priority over
      // any SCK edge. This drops a partial byte and re-arms the next frame.
      if (cs_d) begin
        bit_cnt  <= 3'd0;
        first    <= 1'b1;
        tx_shift <= FRAME_ID;
      end else if (cs_fall) begin
        bit_cnt  <= 3'd0;
        tx_shift <= FRAME_ID;
      end else begin
        if (sck_rise) begin
          rx_shift <= {rx_shift[6:0], mosi_sync};
          bit_cnt  <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            data_out        <= {rx_shift[6:0], mosi_sync};
            data_out_strobe <= 1'b1;
            data_out_start  <= first;
            first           <= 1'b0;
          end
        end
        // The falling edge after the 8th rising edge (counter back at 0)
        // must not shift. By then the next reply byte has been loaded, and
        // its MSB has to stay on MISO until the next byte's first rise.
        if (data_out_strobe) begin
          tx_shift <= reply_in;
        end else if (sck_fall && bit_cnt != 3'd0) begin
          tx_shift <= {tx_shift[6:0], 1'b0};
        end
      end
    end
  end

  assign spi_miso = cs_d ? 1'b0 : tx_shift[7];

endmodule

// File: tb/tb_mcu_spi_target.sv
// Self-checking bench for mcu_spi_target.
//
// The bench acts as the MCU. It drives mode-0 SPI at clk/8 and captures
// MISO on each rising SCK. For every complete byte it sent, it records the
// byte, whether it was the first byte of the frame, and the cycle in which
// the strobe must appear. A per-cycle compare process checks the DUT
// against that expectation list. It also checks that data_out holds
// between strobes and that MISO is quiet while the link is idle.
module tb_mcu_spi_target;
  import mcu_link_pkg::*;

  localparam int         SYNC_STAGES = 2;
  localparam logic [7:0] FRAME_ID    = 8'h5C;

  logic       clk = 1'b0;
  logic       reset;
  logic       spi_csn, spi_sck, spi_mosi, spi_miso;
  logic [7:0] reply_in;
  logic       data_out_strobe, data_out_start;
  logic [7:0] data_out;

  mcu_spi_target #(.SYNC_STAGES(SYNC_STAGES), .FRAME_ID(FRAME_ID)) dut (
    .clk             (clk),
    .reset           (reset),
    .spi_csn         (spi_csn),
    .spi_sck         (spi_sck),
    .spi_mosi        (spi_mosi),
    .spi_miso        (spi_miso),
    .reply_in        (reply_in),
    .data_out_strobe (data_out_strobe),
    .data_out_start  (data_out_start),
    .data_out        (data_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic       start;
    int         due;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       cur;
  logic [7:0] miso_log[$];
  int         checks = 0;
  int         errors = 0;
  int         cycle = 0;
  int         cs_high_cycles = 0;
  int         strobe_seen = 0;
  int         frame_idx = 0;
  logic [7:0] model_data = 8'h00;
  logic [7:0] start_hist = 8'h00;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)",
               name, actual, expected, cycle);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  always @(posedge clk) begin
    cycle++;
    if (spi_csn) cs_high_cycles++;
    else cs_high_cycles = 0;
  end

  // Compare process: cycle-exact strobe, data, start, hold and idle MISO.
  always @(negedge clk) begin
    if (reset) begin
      model_data = 8'h00;
    end else begin
      if (exp_q.size() != 0 && exp_q[0].due == cycle) begin
        cur = exp_q.pop_front();
        checkOutput("strobe_on_time", 32'(data_out_strobe), 32'(1'b1));
        checkOutput("data_out", 32'(data_out), 32'(cur.data));
        checkOutput("data_out_start", 32'(data_out_start), 32'(cur.start));
        model_data = cur.data;
        if (data_out_strobe) begin
          strobe_seen++;
          start_hist = {start_hist[6:0], data_out_start};
        end
      end else begin
        checkOutput("no_stray_strobe", 32'(data_out_strobe), 32'(1'b0));
        checkOutput("data_out_hold", 32'(data_out), 32'(model_data));
      end
      if (cs_high_cycles >= SYNC_STAGES + 2)
        checkOutput("miso_idle", 32'(spi_miso), 32'(1'b0));
    end
  end

  task automatic frame_begin();
    spi_csn   = 1'b0;
    frame_idx = 0;
    tick(6);
  endtask

  task automatic frame_end(input int idle);
    tick(4);
    spi_csn = 1'b1;
    tick(idle);
  endtask

  // Sends nbits of b MSB first, with SCK low and high for 4 clk each. MISO
  // is captured just before each rising edge. A complete byte schedules its
  // strobe SYNC_STAGES+2 edges after the first edge that sees bit 8 high,
  // counting that edge as the first.
  task automatic applyStimulus(input logic [7:0] b, input int nbits);
    logic [7:0] got;
    logic [7:0] exp_reply;
    exp_t       e;
    got       = 8'h00;
    exp_reply = (frame_idx == 0) ? FRAME_ID : reply_in;
    for (int i = 0; i < nbits; i++) begin
      spi_mosi = b[7-i];
      tick(4);
      got     = {got[6:0], spi_miso};
      spi_sck = 1'b1;
      if (i == 7) begin
        e.data  = b;
        e.start = (frame_idx == 0);
        e.due   = cycle + SYNC_STAGES + 2;
        exp_q.push_back(e);
      end
      tick(4);
      spi_sck = 1'b0;
    end
    if (nbits == 8) begin
      checkOutput("miso_byte", 32'(got), 32'(exp_reply));
      miso_log.push_back(got);
      frame_idx++;
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: time limit reached, got %0d strobes", strobe_seen);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset    = 1'b1;
    spi_csn  = 1'b1;
    spi_sck  = 1'b0;
    spi_mosi = 1'b0;
    reply_in = 8'h00;
    tick(3);
    reset = 1'b0;
    tick(1);
    checkOutput("reset_strobe", 32'(data_out_strobe), 32'(1'b0));
    checkOutput("reset_data_out", 32'(data_out), 32'(8'h00));
    checkOutput("reset_miso", 32'(spi_miso), 32'(1'b0));

    // Idle with CS high.
    tick(50);
    checkOutput("idle_data_out", 32'(data_out), 32'(8'h00));
    checkOutput("idle_miso", 32'(spi_miso), 32'(1'b0));
    checkOutput("idle_strobes", 32'(strobe_seen), 32'(0));

    // Three-byte frame.
    frame_begin();
    applyStimulus(8'h02, 8);
    applyStimulus(8'h05, 8);
    applyStimulus(8'hA5, 8);
    frame_end(10);
    checkOutput("frame1_last_data", 32'(data_out), 32'(8'hA5));
    checkOutput("frame1_strobes", 32'(strobe_seen), 32'(3));
    checkOutput("frame1_starts", 32'(start_hist[2:0]), 32'(3'b100));

    // MISO reply path.
    reply_in = 8'h3C;
    frame_begin();
    applyStimulus(8'h11, 8);
    applyStimulus(8'h22, 8);
    frame_end(10);
    checkOutput("miso_first_reply", 32'(miso_log[3]), 32'(8'h5C));
    checkOutput("miso_second_reply", 32'(miso_log[4]), 32'(8'h3C));

    // Abort after 5 bits, then a fresh single-byte frame.
    frame_begin();
    applyStimulus(8'hFF, 5);
    frame_end(10);
    checkOutput("abort_no_strobe", 32'(strobe_seen), 32'(5));
    checkOutput("abort_data_kept", 32'(data_out), 32'(8'h22));
    frame_begin();
    applyStimulus(8'h01, 8);
    frame_end(10);
    checkOutput("after_abort_data", 32'(data_out), 32'(8'h01));
    checkOutput("after_abort_start", 32'(start_hist[0]), 32'(1'b1));

    // Back-to-back frames with a short CS-high gap.
    frame_begin();
    applyStimulus(8'h44, 8);
    applyStimulus(8'h55, 8);
    frame_end(SYNC_STAGES + 1);
    frame_begin();
    applyStimulus(8'h66, 8);
    frame_end(10);
    checkOutput("b2b_starts", 32'(start_hist[2:0]), 32'(3'b101));
    checkOutput("b2b_reload_frame_id", 32'(miso_log[miso_log.size()-1]), 32'(8'h5C));
    checkOutput("b2b_strobes", 32'(strobe_seen), 32'(9));

    // Reset pulsed after 6 bits of 0x81, then a clean frame.
    frame_begin();
    applyStimulus(8'h81, 6);
    reset = 1'b1;
    tick(2);
    spi_csn = 1'b1;
    reset   = 1'b0;
    tick(10);
    checkOutput("reset_mid_byte_strobes", 32'(strobe_seen), 32'(9));
    checkOutput("reset_mid_byte_data", 32'(data_out), 32'(8'h00));
    frame_begin();
    applyStimulus(8'h81, 8);
    frame_end(10);
    checkOutput("post_reset_data", 32'(data_out), 32'(8'h81));
    checkOutput("post_reset_start", 32'(start_hist[0]), 32'(1'b1));
    checkOutput("post_reset_strobes", 32'(strobe_seen), 32'(10));

    tick(20);
    checkOutput("expectations_drained", 32'(exp_q.size()), 32'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
